// File: rtl/race_controller.sv
`default_nettype none
// ============================================================================
// Module   : race_controller
// Purpose  : Race sequencer for the lap stopwatch. It synchronises the raw
//            finish-line sensor and detects crossings. Crossings are debounced
//            with a holdoff window. The module counts laps up to LAPS, records
//            the last and best lap times, and emits the stopwatch control
//            pulses. All outputs are registered.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            go, abort         - race start request / race cancel
//            finish_line       - raw asynchronous line-overlap sensor
//            lap_time          - stopwatch counter value (CNT_W bits)
//            timer_start/stop  - 1-cycle stopwatch start / stop pulses
//            lap_finished      - 1-cycle pulse, stopwatch zeroes its counter
//            lap_num           - completed laps in the current race
//            last_lap/best_lap - most recent / minimum lap time (best=all-ones
//                                means no lap yet)
//            lap_valid         - 1-cycle pulse when last_lap/lap_num update
//            race_done         - high while the race is complete
//            total_time        - sum of lap times (only with RACE_TOTAL_EN)
// Options  : define RACE_TOTAL_EN to add the total_time accumulator output.
// Revision : 1.0 - initial release
// ============================================================================
module race_controller #(
   parameter int LAPS    = 3,
   parameter int CNT_W   = 16,
   parameter int HOLDOFF = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             abort,
   input  logic             finish_line,
   input  logic [CNT_W-1:0] lap_time,
   output logic             timer_start,
   output logic             timer_stop,
   output logic             lap_finished,
   output logic [3:0]       lap_num,
   output logic [CNT_W-1:0] last_lap,
   output logic [CNT_W-1:0] best_lap,
   output logic             lap_valid,
   output logic             race_done
`ifdef RACE_TOTAL_EN
   ,
   output logic [CNT_W+3:0] total_time
`endif
);

   localparam int              HO_W     = $clog2(HOLDOFF + 1);
   localparam logic [HO_W-1:0] HO_LOAD  = HO_W'(HOLDOFF);
   localparam logic [3:0]      LAST_IDX = 4'(LAPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RACING = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       sync_q, sync_d;
   logic [HO_W-1:0]  holdoff_q, holdoff_d;
   logic             timer_start_q, timer_start_d;
   logic             timer_stop_q, timer_stop_d;
   logic             lap_finished_q, lap_finished_d;
   logic [3:0]       lap_num_q, lap_num_d;
   logic [CNT_W-1:0] last_lap_q, last_lap_d;
   logic [CNT_W-1:0] best_lap_q, best_lap_d;
   logic             lap_valid_q, lap_valid_d;
   logic             race_done_q, race_done_d;
`ifdef RACE_TOTAL_EN
   logic [CNT_W+3:0] total_q, total_d;
`endif

   logic line_edge;
   logic edge_ok;

   // sync_q[0] is the metastability catcher; the edge is taken one stage later
   // so a raw pulse seen at a single clock edge still yields one edge.
   assign line_edge = sync_q[1] & ~sync_q[2];
   assign edge_ok   = (state_q == ST_RACING) && line_edge && (holdoff_q == '0);

   always_comb begin
      state_d        = state_q;
      sync_d         = {sync_q[1:0], finish_line};
      holdoff_d      = (holdoff_q != '0) ? holdoff_q - HO_W'(1) : '0;
      timer_start_d  = 1'b0;
      timer_stop_d   = 1'b0;
      lap_finished_d = 1'b0;
      lap_valid_d    = 1'b0;
      lap_num_d      = lap_num_q;
      last_lap_d     = last_lap_q;
      best_lap_d     = best_lap_q;
      race_done_d    = race_done_q;
`ifdef RACE_TOTAL_EN
      total_d        = total_q;
`endif

      // A lap already announced to the stopwatch always completes its capture;
      // lap_time still holds the finished lap in this cycle.
      if (lap_finished_q) begin
         last_lap_d  = lap_time;
         best_lap_d  = (lap_time < best_lap_q) ? lap_time : best_lap_q;
         lap_num_d   = lap_num_q + 4'd1;
         lap_valid_d = 1'b1;
`ifdef RACE_TOTAL_EN
         total_d     = total_q + {4'b0000, lap_time};
`endif
      end

      case (state_q)
         ST_RACING: begin
            if (abort) begin
               // Avoid a second stop pulse if the final lap just stopped the watch.
               timer_stop_d = ~timer_stop_q;
               lap_num_d    = 4'd0;
               state_d      = ST_IDLE;
            end else begin
               // lap_finished together with timer_stop marks the final lap.
               if (lap_finished_q && timer_stop_q) begin
                  state_d     = ST_DONE;
                  race_done_d = 1'b1;
               end
               if (edge_ok) begin
                  lap_finished_d = 1'b1;
                  holdoff_d      = HO_LOAD;
                  timer_stop_d   = (lap_num_q == LAST_IDX);
               end
            end
         end
         default: begin
            if (go && !abort) begin
               timer_start_d = 1'b1;
               lap_num_d     = 4'd0;
               last_lap_d    = '0;
               best_lap_d    = '1;
               holdoff_d     = HO_LOAD;
               race_done_d   = 1'b0;
               state_d       = ST_RACING;
`ifdef RACE_TOTAL_EN
               total_d       = '0;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         sync_q         <= '0;
         holdoff_q      <= '0;
         timer_start_q  <= 1'b0;
         timer_stop_q   <= 1'b0;
         lap_finished_q <= 1'b0;
         lap_num_q      <= 4'd0;
         last_lap_q     <= '0;
         best_lap_q     <= '1;
         lap_valid_q    <= 1'b0;
         race_done_q    <= 1'b0;
`ifdef RACE_TOTAL_EN
         total_q        <= '0;
`endif
      end else begin
         state_q        <= state_d;
         sync_q         <= sync_d;
         holdoff_q      <= holdoff_d;
         timer_start_q  <= timer_start_d;
         timer_stop_q   <= timer_stop_d;
         lap_finished_q <= lap_finished_d;
         lap_num_q      <= lap_num_d;
         last_lap_q     <= last_lap_d;
         best_lap_q     <= best_lap_d;
         lap_valid_q    <= lap_valid_d;
         race_done_q    <= race_done_d;
`ifdef RACE_TOTAL_EN
         total_q        <= total_d;
`endif
      end
   end

   assign timer_start  = timer_start_q;
   assign timer_stop   = timer_stop_q;
   assign lap_finished = lap_finished_q;
   assign lap_num      = lap_num_q;
   assign last_lap     = last_lap_q;
   assign best_lap     = best_lap_q;
   assign lap_valid    = lap_valid_q;
   assign race_done    = race_done_q;
`ifdef RACE_TOTAL_EN
   assign total_time   = total_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_race_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_race_controller
// Purpose  : Directed self-checking bench for race_controller (LAPS=3,
//            CNT_W=16, HOLDOFF=8). An event-level race model predicts every
//            output each cycle. Hand-computed literal checks pin the key
//            results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_race_controller;

   localparam int LAPS    = 3;
   localparam int CNT_W   = 16;
   localparam int HOLDOFF = 8;

   logic             clk;
   logic             rst;
   logic             go;
   logic             abort;
   logic             finish_line;
   logic [CNT_W-1:0] lap_time;
   logic             timer_start;
   logic             timer_stop;
   logic             lap_finished;
   logic [3:0]       lap_num;
   logic [CNT_W-1:0] last_lap;
   logic [CNT_W-1:0] best_lap;
   logic             lap_valid;
   logic             race_done;
`ifdef RACE_TOTAL_EN
   logic [CNT_W+3:0] total_time;
`endif

   race_controller #(
      .LAPS    (LAPS),
      .CNT_W   (CNT_W),
      .HOLDOFF (HOLDOFF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .go           (go),
      .abort        (abort),
      .finish_line  (finish_line),
      .lap_time     (lap_time),
      .timer_start  (timer_start),
      .timer_stop   (timer_stop),
      .lap_finished (lap_finished),
      .lap_num      (lap_num),
      .last_lap     (last_lap),
      .best_lap     (best_lap),
      .lap_valid    (lap_valid),
      .race_done    (race_done)
`ifdef RACE_TOTAL_EN
      ,
      .total_time   (total_time)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- race model ----------------
   // Cycle c is the interval after the c-th posedge. A raw rise first sampled
   // at the edge ending cycle c is a crossing candidate in cycle c+2. An
   // accepted crossing in cycle E blocks new crossings until cycle E+1+HOLDOFF.
   localparam int M_IDLE = 0, M_RACE = 1, M_DONE = 2;
   int          cyc = 0;
   int          m_state;
   int          m_laps;
   int          next_ok;
   int          cross_q[$];
   bit          prev_raw;
   bit          mvalid = 0;
   logic [15:0] m_last, m_best;
   logic [19:0] m_total;
   bit          e_start, e_stop, e_lf, e_valid;

   always @(posedge clk) begin
      int  c;
      bit  crossing;
      bit  n_start, n_stop, n_lf, n_valid;
      c = cyc;
      cyc++;
      if (rst) begin
         m_state = M_IDLE; m_laps = 0; m_last = '0; m_best = '1; m_total = '0;
         next_ok = 0; prev_raw = 0; cross_q.delete();
         e_start = 0; e_stop = 0; e_lf = 0; e_valid = 0;
         mvalid = 1;
      end else if (mvalid) begin
         crossing = 0;
         while (cross_q.size() > 0 && cross_q[0] < c) void'(cross_q.pop_front());
         if (cross_q.size() > 0 && cross_q[0] == c) begin
            crossing = 1;
            void'(cross_q.pop_front());
         end
         if (finish_line && !prev_raw) cross_q.push_back(c + 2);
         prev_raw = finish_line;
         n_start = 0; n_stop = 0; n_lf = 0; n_valid = 0;
         if (e_lf) begin
            m_last  = lap_time;
            if (lap_time < m_best) m_best = lap_time;
            m_laps++;
            m_total = m_total + 20'(lap_time);
            n_valid = 1;
         end
         if (m_state != M_RACE) begin
            if (go && !abort) begin
               n_start = 1; m_laps = 0; m_last = '0; m_best = '1; m_total = '0;
               next_ok = c + 1 + HOLDOFF;
               m_state = M_RACE;
            end
         end else if (abort) begin
            n_stop  = !e_stop;
            m_laps  = 0;
            m_state = M_IDLE;
         end else begin
            if (e_lf && e_stop) m_state = M_DONE;
            if (crossing && c >= next_ok) begin
               n_lf    = 1;
               next_ok = c + 1 + HOLDOFF;
               if (m_laps == LAPS - 1) n_stop = 1;
            end
         end
         e_start = n_start; e_stop = n_stop; e_lf = n_lf; e_valid = n_valid;
      end
   end

   int nvalid = 0;
   always @(negedge clk) begin
      if (mvalid) begin
         chk("m_timer_start",  32'(timer_start),  32'(e_start));
         chk("m_timer_stop",   32'(timer_stop),   32'(e_stop));
         chk("m_lap_finished", 32'(lap_finished), 32'(e_lf));
         chk("m_lap_valid",    32'(lap_valid),    32'(e_valid));
         chk("m_lap_num",      32'(lap_num),      32'(m_laps));
         chk("m_last_lap",     32'(last_lap),     32'(m_last));
         chk("m_best_lap",     32'(best_lap),     32'(m_best));
         chk("m_race_done",    32'(race_done),    32'(m_state == M_DONE));
`ifdef RACE_TOTAL_EN
         chk("m_total_time",   32'(total_time),   32'(m_total));
`endif
         if (lap_valid === 1'b1) nvalid++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_race();
      go = 1'b1;
      tick(1);
      go = 1'b0;
      tick(12);
   endtask

   // One crossing; lap_finished must appear three edges after the raw rise.
   task automatic lap(input logic [15:0] lt, input logic exp_stop,
                      input int exp_num, input logic [15:0] exp_best);
      lap_time    = lt;
      finish_line = 1'b1;
      tick(3);
      chk("lap_finished_latency", 32'(lap_finished), 32'd1);
      chk("lap_stop",             32'(timer_stop),   32'(exp_stop));
      finish_line = 1'b0;
      tick(1);
      chk("lap_valid_pulse", 32'(lap_valid), 32'd1);
      chk("lap_num",         32'(lap_num),   32'(exp_num));
      chk("lap_last",        32'(last_lap),  32'(lt));
      chk("lap_best",        32'(best_lap),  32'(exp_best));
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; abort = 1'b0; finish_line = 1'b0; lap_time = '0;
      tick(2);
      chk("rst_lap_num",   32'(lap_num),      32'd0);
      chk("rst_last_lap",  32'(last_lap),     32'd0);
      chk("rst_best_lap",  32'(best_lap),     32'hFFFF);
      chk("rst_race_done", 32'(race_done),    32'd0);
      chk("rst_pulses",    32'({timer_start, timer_stop, lap_finished, lap_valid}), 32'd0);
      rst = 1'b0;
      tick(1);

      // start pulse, then a go while racing is ignored
      go = 1'b1;
      tick(1);
      go = 1'b0;
      chk("start_pulse", 32'(timer_start), 32'd1);
      tick(1);
      chk("start_one_cycle", 32'(timer_start), 32'd0);
      go = 1'b1;
      tick(1);
      go = 1'b0;
      chk("go_in_racing", 32'(timer_start), 32'd0);
      tick(12);

      // three-lap race
      nvalid = 0;
      lap(16'd100, 1'b0, 1, 16'd100);
      tick(12);
      lap(16'd80, 1'b0, 2, 16'd80);
      tick(12);
      lap(16'd120, 1'b1, 3, 16'd80);
      chk("race_done_after_final", 32'(race_done), 32'd1);
`ifdef RACE_TOTAL_EN
      chk("total_time_300", 32'(total_time), 32'd300);
`endif
      tick(1);
      chk("lap_valid_count", 32'(nvalid), 32'd3);

      // crossing in DONE is ignored
      finish_line = 1'b1;
      tick(3);
      chk("done_no_lap", 32'(lap_finished), 32'd0);
      finish_line = 1'b0;
      tick(12);
      chk("done_hold_laps", 32'(lap_num), 32'd3);

      // holdoff: a quick second crossing is ignored
      start_race();
      lap(16'd50, 1'b0, 1, 16'd50);
      finish_line = 1'b1;
      tick(3);
      chk("holdoff_no_lap", 32'(lap_finished), 32'd0);
      finish_line = 1'b0;
      tick(12);
      chk("holdoff_lap_num", 32'(lap_num), 32'd1);

      // abort in the same cycle as an edge
      finish_line = 1'b1;
      tick(2);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      finish_line = 1'b0;
      chk("abort_stop",      32'(timer_stop),   32'd1);
      chk("abort_no_lap",    32'(lap_finished), 32'd0);
      chk("abort_lap_num",   32'(lap_num),      32'd0);
      chk("abort_keep_last", 32'(last_lap),     32'd50);
      chk("abort_keep_best", 32'(best_lap),     32'd50);
      tick(1);
      chk("abort_stop_once", 32'(timer_stop),   32'd0);
      chk("abort_no_late",   32'(lap_finished), 32'd0);
      tick(2);

      // go together with abort in IDLE does not start
      go = 1'b1; abort = 1'b1;
      tick(1);
      go = 1'b0; abort = 1'b0;
      chk("go_abort_idle", 32'(timer_start), 32'd0);
      tick(2);

      // reset with a lap in flight
      start_race();
      lap_time    = 16'd77;
      finish_line = 1'b1;
      tick(3);
      chk("pre_rst_lap", 32'(lap_finished), 32'd1);
      rst = 1'b1;
      finish_line = 1'b0;
      tick(1);
      rst = 1'b0;
      chk("rst_mid_valid",   32'(lap_valid), 32'd0);
      chk("rst_mid_lap_num", 32'(lap_num),   32'd0);
      chk("rst_mid_last",    32'(last_lap),  32'd0);
      chk("rst_mid_best",    32'(best_lap),  32'hFFFF);
      tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
